// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   DEFAULT_ADDR_W / DEFAULT_DATA_W : default bus widths (7-bit byte address, 32-bit word)
//   port_id_t                       : requester index (0 = core datapath, 1 = loader/debug)
//   state_e                         : sequencer states
package dmem_arb_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 7;
    localparam int unsigned DEFAULT_DATA_W = 32;

    typedef logic port_id_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

endpackage

// File: rtl/dmem_rr_picker.sv
// Combinational two-way round-robin pick.
//   req         : request per port
//   eligible    : ports allowed to win this cycle
//   last_grant  : port granted most recently
//   grant_valid : some eligible port is requesting
//   grant_id    : winning port (meaningful only when grant_valid)
module dmem_rr_picker
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] eligible,
    input  port_id_t   last_grant,
    output logic       grant_valid,
    output port_id_t   grant_id
);

    logic [1:0] cand;

    assign cand = req & eligible;

    always_comb begin
        grant_valid = |cand;
        grant_id    = 1'b0;
        if (&cand) begin
            // Tie: favour the port that did not win last time.
            grant_id = ~last_grant;
        end else begin
            grant_id = cand[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of a single-ported data memory.
// Port 0 is the core datapath, port 1 the loader/debug port. Each access takes
// one ACCESS cycle on the memory bus followed by a RESP cycle carrying the ack;
// the other port may be granted during RESP so alternating ports run back to back.
//   clock, reset                 : clock, synchronous active-high reset
//   req/we/addr/wdata{0,1}       : per-port command, held until ack
//   ack{0,1}, rdata{0,1}         : completion pulse and held load data
//   mem_address/write/read/wdata : registered memory bus
//   mem_rdata                    : memory read data (updated on negedge)
//   busy                         : high in ACCESS and RESP
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_e            state_q, state_d;
    port_id_t          last_grant_q;
    port_id_t          cmd_id_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_write_q, mem_read_q;
    logic              ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              busy_q;

    logic [1:0] eligible;
    logic       grant_valid;
    port_id_t   grant_id;

    // In RESP the acked port still holds req high, so only the other port may win.
    always_comb begin
        eligible = 2'b00;
        unique case (state_q)
            StIdle:  eligible = 2'b11;
            StResp:  eligible = cmd_id_q ? 2'b01 : 2'b10;
            default: eligible = 2'b00;
        endcase
    end

    dmem_rr_picker u_picker (
        .req         ({req1, req0}),
        .eligible    (eligible),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant_valid) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = grant_valid ? StAccess : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            cmd_id_q      <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != StIdle);
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;

            // The bus registers double as the command latch for the ACCESS cycle.
            if (grant_valid) begin
                last_grant_q  <= grant_id;
                cmd_id_q      <= grant_id;
                mem_address_q <= grant_id ? addr1 : addr0;
                mem_wdata_q   <= grant_id ? wdata1 : wdata0;
                mem_write_q   <= grant_id ? we1 : we0;
                mem_read_q    <= grant_id ? !we1 : !we0;
            end

            if (state_q == StAccess) begin
                if (cmd_id_q) begin
                    ack1_q <= 1'b1;
                    if (mem_read_q) rdata1_q <= mem_rdata;
                end else begin
                    ack0_q <= 1'b1;
                    if (mem_read_q) rdata0_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_write   = mem_write_q;
    assign mem_read    = mem_read_q;
    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// two-requester run scored against a transaction-level memory model.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [6:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [6:0]  mem_address;
    logic        mem_write, mem_read;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:31];

    dmem_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .ack0        (ack0),
        .ack1        (ack1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .mem_address (mem_address),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: word i starts at i+2, writes commit at posedge.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'(i + 2);
        forever begin
            @(posedge clock);
            if (mem_write) mem[mem_address[6:2]] = mem_wdata;
        end
    end

    always @(negedge clock) mem_rdata <= mem[mem_address[6:2]];

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1;
        step();
        step();
        vectors++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ack: got ack0=%b ack1=%b, want 0 0", ack0, ack1);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b, want 0", busy);
        end
        vectors++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mem_ctl: got write=%b read=%b, want 0 0", mem_write, mem_read);
        end
        vectors++;
        if (mem_address !== 7'h00 || mem_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h, want 00 0", mem_address, mem_wdata);
        end
        vectors++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h %h, want 0 0", rdata0, rdata1);
        end
        reset = 0;
        step();
        vectors++;
        if (busy !== 1'b0 || ack0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b ack0=%b, want 0 0", busy, ack0);
        end
    endtask

    task automatic test_single_load;
        req0 = 1; we0 = 0; addr0 = 7'h00;
        step();
        vectors++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 7'h00 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_access: got read=%b write=%b addr=%h busy=%b, want 1 0 00 1",
                     mem_read, mem_write, mem_address, busy);
        end
        vectors++;
        if (ack0 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early_ack: got ack0=%b, want 0", ack0);
        end
        step();
        vectors++;
        if (ack0 !== 1'b1 || rdata0 !== 32'd2 || ack1 !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ack: got ack0=%b rdata0=%h ack1=%b, want 1 2 0", ack0, rdata0, ack1);
        end
        req0 = 0;
        step();
        vectors++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0 || mem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL single_after: got ack0=%b ack1=%b busy=%b read=%b, want 0 0 0 0",
                     ack0, ack1, busy, mem_read);
        end
    endtask

    task automatic test_tie;
        int last_port;
        int n_acks;
        reset = 1;
        req0 = 1; we0 = 0; addr0 = 7'h04;
        req1 = 1; we1 = 0; addr1 = 7'h08;
        step();
        reset = 0;
        step();
        vectors++;
        if (mem_address !== 7'h04 || mem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL tie_first_access: got addr=%h read=%b, want 04 1", mem_address, mem_read);
        end
        step();
        vectors++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata0 !== 32'd3) begin
            miscompares++;
            $display("FAIL tie_ack0: got ack0=%b ack1=%b rdata0=%h, want 1 0 3", ack0, ack1, rdata0);
        end
        step();
        vectors++;
        if (mem_address !== 7'h08 || mem_read !== 1'b1 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_second_access: got addr=%h read=%b ack0=%b ack1=%b, want 08 1 0 0",
                     mem_address, mem_read, ack0, ack1);
        end
        step();
        vectors++;
        if (ack1 !== 1'b1 || rdata1 !== 32'd4) begin
            miscompares++;
            $display("FAIL tie_ack1: got ack1=%b rdata1=%h, want 1 4", ack1, rdata1);
        end
        last_port = 1;
        n_acks = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                vectors++;
                if ((ack0 === 1'b1 && ack1 === 1'b1) || int'(ack1) == last_port) begin
                    miscompares++;
                    $display("FAIL tie_alternate: got ack0=%b ack1=%b after port %0d", ack0, ack1,
                             last_port);
                end
                last_port = int'(ack1);
                n_acks++;
            end
        end
        vectors++;
        if (n_acks != 6) begin
            miscompares++;
            $display("FAIL tie_throughput: got %0d acks in 12 cycles, want 6", n_acks);
        end
        idle_inputs();
        repeat (4) step();
    endtask

    task automatic test_store_load;
        int wcount;
        wcount = 0;
        req1 = 1; we1 = 1; addr1 = 7'h08; wdata1 = 32'hDEADBEEF;
        step();
        wcount += int'(mem_write);
        vectors++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 7'h08 ||
            mem_wdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL store_access: got write=%b read=%b addr=%h wdata=%h, want 1 0 08 deadbeef",
                     mem_write, mem_read, mem_address, mem_wdata);
        end
        step();
        wcount += int'(mem_write);
        vectors++;
        if (ack1 !== 1'b1) begin
            miscompares++;
            $display("FAIL store_ack: got ack1=%b, want 1", ack1);
        end
        req1 = 0;
        req0 = 1; we0 = 0; addr0 = 7'h08;
        step();
        wcount += int'(mem_write);
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== 7'h08) begin
            miscompares++;
            $display("FAIL load_access: got read=%b addr=%h, want 1 08", mem_read, mem_address);
        end
        step();
        wcount += int'(mem_write);
        vectors++;
        if (ack0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL load_back: got ack0=%b rdata0=%h, want 1 deadbeef", ack0, rdata0);
        end
        req0 = 0;
        step();
        wcount += int'(mem_write);
        vectors++;
        if (wcount != 1) begin
            miscompares++;
            $display("FAIL store_once: got %0d write cycles, want 1", wcount);
        end
    endtask

    task automatic test_fairness;
        int acks0, acks1, gap, cyc;
        acks0 = 0; acks1 = 0; gap = 0; cyc = 0;
        req1 = 1; we1 = 0; addr1 = 7'h0C;
        req0 = 1; we0 = 0; addr0 = 7'h00;
        while (acks0 < 5 && cyc < 60) begin
            step();
            cyc++;
            gap++;
            if (ack1 === 1'b1) acks1++;
            if (ack0 === 1'b1) begin
                acks0++;
                vectors++;
                if (rdata0 !== 32'd2 || (acks0 > 1 && gap > 4)) begin
                    miscompares++;
                    $display("FAIL fair_ack0: got rdata0=%h gap=%0d, want 2 and gap<=4", rdata0, gap);
                end
                gap = 0;
                if (acks0 == 5) req0 = 0;
            end
        end
        vectors++;
        if (acks0 != 5 || acks1 < 4) begin
            miscompares++;
            $display("FAIL fair_count: got ack0 count %0d ack1 count %0d, want 5 and >=4", acks0, acks1);
        end
        idle_inputs();
        repeat (4) step();
    endtask

    task automatic test_pulse;
        req0 = 1; we0 = 1; addr0 = 7'h04; wdata0 = 32'd7;
        step();
        req0 = 0;
        vectors++;
        if (mem_write !== 1'b1 || mem_address !== 7'h04 || mem_wdata !== 32'd7) begin
            miscompares++;
            $display("FAIL pulse_access: got write=%b addr=%h wdata=%h, want 1 04 7",
                     mem_write, mem_address, mem_wdata);
        end
        step();
        vectors++;
        if (ack0 !== 1'b1) begin
            miscompares++;
            $display("FAIL pulse_ack: got ack0=%b, want 1", ack0);
        end
        step();
        vectors++;
        if (mem[1] !== 32'd7 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_word: got word1=%h busy=%b, want 7 0", mem[1], busy);
        end
    endtask

    task automatic test_reset_access;
        req1 = 1; we1 = 0; addr1 = 7'h10;
        step();
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== 7'h10) begin
            miscompares++;
            $display("FAIL rst_acc_access: got read=%b addr=%h, want 1 10", mem_read, mem_address);
        end
        reset = 1;
        req1 = 0;
        step();
        vectors++;
        if (ack1 !== 1'b0 || busy !== 1'b0 || rdata1 !== 32'h0 || rdata0 !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_acc_state: got ack1=%b busy=%b rdata1=%h rdata0=%h, want 0 0 0 0",
                     ack1, busy, rdata1, rdata0);
        end
        vectors++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_address !== 7'h00 ||
            mem_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_acc_bus: got write=%b read=%b addr=%h wdata=%h, want all 0",
                     mem_write, mem_read, mem_address, mem_wdata);
        end
        reset = 0;
        step();
        vectors++;
        if (ack1 !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_acc_after: got ack1=%b busy=%b, want 0 0", ack1, busy);
        end
    endtask

    // Transaction-level model: each port has at most one outstanding command;
    // the memory image is updated in ack order, which is also access order.
    task automatic test_random;
        logic [31:0] ref_mem [0:31];
        bit          pend [2];
        logic        pwe [2];
        logic [6:0]  paddr [2];
        logic [31:0] pwd [2];
        int          age [2];
        logic [31:0] exp_rd [2];
        logic [1:0]  a;
        logic [31:0] rd [2];
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; pwe[p] = 0; paddr[p] = '0; pwd[p] = '0; age[p] = 0; exp_rd[p] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            a = {ack1, ack0};
            rd[0] = rdata0;
            rd[1] = rdata1;
            vectors++;
            if (a === 2'b11 || (mem_write === 1'b1 && mem_read === 1'b1)) begin
                miscompares++;
                $display("FAIL rand_exclusive: got acks=%b write=%b read=%b", a, mem_write, mem_read);
            end
            for (int p = 0; p < 2; p++) begin
                if (a[p] === 1'b1) begin
                    vectors++;
                    age[p]++;
                    if (!pend[p] || age[p] > 5) begin
                        miscompares++;
                        $display("FAIL rand_ack%0d: got ack pending=%0d age=%0d, want pending and age<=5",
                                 p, pend[p], age[p]);
                    end
                    if (pend[p]) begin
                        if (pwe[p]) ref_mem[paddr[p][6:2]] = pwd[p];
                        else exp_rd[p] = ref_mem[paddr[p][6:2]];
                    end
                    pend[p] = 0;
                end else if (pend[p]) begin
                    age[p]++;
                    if (age[p] > 5) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rand_timeout%0d: got no ack after %0d cycles, want <=5", p, age[p]);
                        pend[p] = 0;
                    end
                end
                vectors++;
                if (rd[p] !== exp_rd[p]) begin
                    miscompares++;
                    $display("FAIL rand_rdata%0d: got %h, want %h", p, rd[p], exp_rd[p]);
                end
                if (!pend[p] && $urandom_range(0, 99) < 60) begin
                    pend[p]  = 1;
                    pwe[p]   = 1'($urandom_range(0, 1));
                    paddr[p] = 7'($urandom_range(0, 127));
                    pwd[p]   = $urandom;
                    age[p]   = 0;
                end
            end
            req0 = pend[0]; we0 = pwe[0]; addr0 = paddr[0]; wdata0 = pwd[0];
            req1 = pend[1]; we1 = pwe[1]; addr1 = paddr[1]; wdata1 = pwd[1];
        end
        idle_inputs();
        repeat (4) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_single_load();
        test_tie();
        test_store_load();
        test_fairness();
        test_pulse();
        test_reset_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
